// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg
//   Shared constants and types for the round-robin stream multiplexer.
//   DEFAULT_N        : default data width per channel in bits
//   DEFAULT_CHANNELS : default number of input channels
//   mode_e           : arbitration mode (round-robin or fixed selection)
package rr_mux_pkg;

  localparam int DEFAULT_N        = 1;
  localparam int DEFAULT_CHANNELS = 32;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Picks one requesting channel per cycle, either by a rotating round-robin
//   search or by a fixed channel index, and owns the rotation pointer.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     req          : per-channel request (the in_valid vector)
//     mode         : MODE_RR or MODE_FIXED
//     select       : channel index used in MODE_FIXED
//     advance      : an input transfer happens on the coming edge
//     grant        : one-hot grant, zero when nothing is granted
//     grant_idx    : index of the granted channel (zero when no grant)
//     grant_valid  : a channel is granted this cycle
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter  int CHANNELS = DEFAULT_CHANNELS,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] req,
  input  mode_e               mode,
  input  logic [SEL_W-1:0]    select,
  input  logic                advance,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx,
  output logic                grant_valid
);

  logic [SEL_W-1:0] ptr;
  logic             rr_hit;
  logic [SEL_W-1:0] rr_idx;
  logic             fx_hit;
  int               rr_cand;
  logic [SEL_W-1:0] rr_cand_idx;

  // Wrap-around search: visit channels ptr, ptr+1, ... CHANNELS-1, 0, ...
  // and keep the first one requesting. ptr is always below CHANNELS, so a
  // single subtraction is enough to fold the candidate back into range.
  always_comb begin
    rr_hit      = 1'b0;
    rr_idx      = '0;
    rr_cand     = 0;
    rr_cand_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rr_cand = int'(ptr) + i;
      if (rr_cand >= CHANNELS) begin
        rr_cand = rr_cand - CHANNELS;
      end
      rr_cand_idx = rr_cand[SEL_W-1:0];
      if (!rr_hit && req[rr_cand_idx]) begin
        rr_hit = 1'b1;
        rr_idx = rr_cand_idx;
      end
    end
  end

  // A select value beyond the last channel can exist when CHANNELS is not a
  // power of two; it never grants.
  always_comb begin
    fx_hit = 1'b0;
    if (int'(select) < CHANNELS) begin
      fx_hit = req[select];
    end
  end

  // Mode selects which search result drives the grant outputs.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    if (mode == MODE_FIXED) begin
      grant_valid = fx_hit;
      grant_idx   = fx_hit ? select : '0;
    end else begin
      grant_valid = rr_hit;
      grant_idx   = rr_idx;
    end
    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Pointer moves just past the winner on round-robin transfers only, so
  // fixed-mode traffic leaves the rotation where it was.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && grant_valid && (mode == MODE_RR)) begin
      if (int'(grant_idx) == CHANNELS - 1) begin
        ptr <= '0;
      end else begin
        ptr <= grant_idx + SEL_W'(1);
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux
//   Multiplexes CHANNELS valid/ready input streams onto one registered output
//   stream, arbitrating round-robin or by a fixed channel index.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     in_data      : flattened channel data, channel k at [k*N +: N]
//     in_valid     : per-channel valid
//     in_ready     : per-channel ready, one-hot or zero
//     fixed_mode   : 0 = round-robin, 1 = fixed selection
//     select       : channel index used when fixed_mode = 1
//     out_data     : registered selected data
//     out_valid    : registered output valid
//     out_ready    : downstream ready
//     out_channel  : channel index of the word in the output register
module rr_stream_mux
  import rr_mux_pkg::*;
#(
  parameter  int N        = DEFAULT_N,
  parameter  int CHANNELS = DEFAULT_CHANNELS,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS*N-1:0] in_data,
  input  logic [CHANNELS-1:0]   in_valid,
  output logic [CHANNELS-1:0]   in_ready,
  input  logic                  fixed_mode,
  input  logic [SEL_W-1:0]      select,
  output logic [N-1:0]          out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_channel
);

  logic                load;
  logic                in_xfer;
  mode_e               mode;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;
  logic                grant_valid;
  logic [N-1:0]        sel_data;

  // The output register can take a new word when it is empty or being
  // drained this cycle, which gives one word per cycle with no bubble.
  assign load    = ~out_valid | out_ready;
  assign mode    = fixed_mode ? MODE_FIXED : MODE_RR;
  // rst_n gates ready so nothing is accepted while the block is held in reset.
  assign in_ready = (rst_n && load && grant_valid) ? grant : '0;
  assign in_xfer  = |(in_valid & in_ready);

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arbiter (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (in_valid),
    .mode        (mode),
    .select      (select),
    .advance     (in_xfer),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Data mux indexed by the granted channel.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant_idx == SEL_W'(k)) begin
        sel_data = in_data[k*N +: N];
      end
    end
  end

  // Output register: capture on an input transfer, otherwise drop valid once
  // the held word has been taken; data and channel hold until replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_channel <= '0;
    end else if (in_xfer) begin
      out_valid   <= 1'b1;
      out_data    <= sel_data;
      out_channel <= grant_idx;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux
//   Directed bench for rr_stream_mux (N=8, CHANNELS=32) plus a CHANNELS=20
//   instance for the out-of-range select case. Stimulus pushes each expected
//   output word into a queue; a monitor pops and compares on every output
//   transfer.
module tb_rr_stream_mux;

  localparam int N    = 8;
  localparam int CH   = 32;
  localparam int SW   = 5;
  localparam int CH20 = 20;
  localparam int SW20 = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [CH*N-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic            fixed_mode;
  logic [SW-1:0]   select;
  logic [N-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_channel;

  logic [CH20*N-1:0] in_data20;
  logic [CH20-1:0]   in_valid20;
  logic [CH20-1:0]   in_ready20;
  logic              fixed_mode20;
  logic [SW20-1:0]   select20;
  logic [N-1:0]      out_data20;
  logic              out_valid20;
  logic              out_ready20;
  logic [SW20-1:0]   out_channel20;

  typedef struct packed {
    logic [SW-1:0] ch;
    logic [N-1:0]  data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  int   start_pops;

  always #5 clk = ~clk;

  rr_stream_mux #(.N(N), .CHANNELS(CH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .fixed_mode  (fixed_mode),
    .select      (select),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_channel (out_channel)
  );

  rr_stream_mux #(.N(N), .CHANNELS(CH20)) dut20 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data20),
    .in_valid    (in_valid20),
    .in_ready    (in_ready20),
    .fixed_mode  (fixed_mode20),
    .select      (select20),
    .out_data    (out_data20),
    .out_valid   (out_valid20),
    .out_ready   (out_ready20),
    .out_channel (out_channel20)
  );

  // Channel data pattern: byte = ch*5 + salt.
  function automatic logic [N-1:0] pat(input int ch, input int salt);
    return N'((ch * 5 + salt) & 255);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [CH-1:0] valid, input logic fixed,
                               input logic [SW-1:0] sel, input logic ready,
                               input int salt);
    in_valid   = valid;
    fixed_mode = fixed;
    select     = sel;
    out_ready  = ready;
    for (int k = 0; k < CH; k++) begin
      in_data[k*N +: N] = pat(k, salt);
    end
  endtask

  task automatic pushExpected(input int ch, input logic [N-1:0] d);
    exp_t e;
    e.ch   = SW'(ch);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    in_valid = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every output transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_word: got ch %0d data 0x%0h, expected no word",
                 out_channel, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("word_channel", 64'(out_channel), 64'(mon_e.ch));
        checkOutput("word_data", 64'(out_data), 64'(mon_e.data));
      end
      pops++;
    end
  end

  initial begin
    applyStimulus('1, 1'b0, '0, 1'b1, 0);
    in_valid20   = '0;
    fixed_mode20 = 1'b0;
    select20     = '0;
    out_ready20  = 1'b1;
    for (int k = 0; k < CH20; k++) begin
      in_data20[k*N +: N] = pat(k, 9);
    end

    // Reset state, with every channel requesting.
    #12;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_data", 64'(out_data), 64'd0);
    checkOutput("reset_out_channel", 64'(out_channel), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
    in_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full round-robin sweep: 0..31 then 0 again, one word per cycle.
    $display("[TB] round-robin sweep");
    applyStimulus('1, 1'b0, '0, 1'b1, 0);
    start_pops = pops;
    for (int i = 0; i < 33; i++) begin
      pushExpected(i % 32, pat(i % 32, 0));
    end
    @(negedge clk);
    checkOutput("rr_first_ready", 64'(in_ready), 64'h1);
    repeat (33) @(posedge clk);
    #1;
    in_valid = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rr_throughput", 64'(pops - start_pops), 64'd33);
    idle(2);

    // Pointer wrap: grant 30 moves ptr to 31, then 5, 30, 5.
    $display("[TB] pointer wrap");
    applyStimulus(32'h4000_0000, 1'b0, '0, 1'b1, 1);
    pushExpected(30, pat(30, 1));
    @(posedge clk);
    #1;
    applyStimulus(32'h4000_0020, 1'b0, '0, 1'b1, 1);
    pushExpected(5, pat(5, 1));
    pushExpected(30, pat(30, 1));
    pushExpected(5, pat(5, 1));
    @(negedge clk);
    checkOutput("wrap_ready_5a", 64'(in_ready), 64'h20);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("wrap_ready_30", 64'(in_ready), 64'h4000_0000);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("wrap_ready_5b", 64'(in_ready), 64'h20);
    @(posedge clk);
    #1;
    idle(2);

    // Back-pressure: 0xA5 held while out_ready is low, 0x5A follows.
    $display("[TB] back-pressure hold");
    applyStimulus(32'h8, 1'b0, '0, 1'b0, 2);
    in_data[3*N +: N] = 8'hA5;
    pushExpected(3, 8'hA5);
    @(posedge clk);
    #1;
    in_data[3*N +: N] = 8'h5A;
    repeat (4) begin
      @(negedge clk);
      checkOutput("hold_data", 64'(out_data), 64'hA5);
      checkOutput("hold_valid", 64'(out_valid), 64'd1);
      checkOutput("hold_channel", 64'(out_channel), 64'd3);
      checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    pushExpected(3, 8'h5A);
    @(posedge clk);
    #1;
    idle(2);

    // Fixed mode: select 7 not valid -> no grant; then 7 granted; ptr kept at 4.
    $display("[TB] fixed mode");
    applyStimulus(32'hFFFF_FF7F, 1'b1, 5'd7, 1'b1, 3);
    repeat (2) begin
      @(negedge clk);
      checkOutput("fixed_nogrant_ready", 64'(in_ready), 64'd0);
      checkOutput("fixed_nogrant_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus('1, 1'b1, 5'd7, 1'b1, 3);
    pushExpected(7, pat(7, 3));
    @(negedge clk);
    checkOutput("fixed_ready_7", 64'(in_ready), 64'h80);
    @(posedge clk);
    #1;
    applyStimulus('1, 1'b0, 5'd7, 1'b1, 3);
    pushExpected(4, pat(4, 3));
    @(negedge clk);
    checkOutput("ptr_kept_ready_4", 64'(in_ready), 64'h10);
    @(posedge clk);
    #1;
    idle(2);

    // CHANNELS=20 with select 25: never grants.
    $display("[TB] out-of-range select");
    in_valid20   = '1;
    fixed_mode20 = 1'b1;
    select20     = 5'd25;
    repeat (4) begin
      @(negedge clk);
      checkOutput("sel25_out_valid", 64'(out_valid20), 64'd0);
      checkOutput("sel25_in_ready", 64'(in_ready20), 64'd0);
    end
    @(posedge clk);
    #1;
    fixed_mode20 = 1'b0;
    in_valid20   = 20'h8_0000;
    @(negedge clk);
    checkOutput("ch20_ready_19", 64'(in_ready20), 64'h8_0000);
    @(posedge clk);
    #1;
    in_valid20 = 20'h0_0002;
    @(negedge clk);
    checkOutput("ch20_out_channel", 64'(out_channel20), 64'd19);
    checkOutput("ch20_out_data", 64'(out_data20), 64'(pat(19, 9)));
    checkOutput("ch20_ready_1", 64'(in_ready20), 64'h2);
    @(posedge clk);
    #1;
    in_valid20 = '0;

    // Reset mid-stream: held word (ch 7) is discarded, restart at channel 0.
    $display("[TB] reset mid-stream");
    applyStimulus('1, 1'b0, '0, 1'b1, 4);
    pushExpected(5, pat(5, 4));
    pushExpected(6, pat(6, 4));
    pushExpected(7, pat(7, 4));
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_out_channel", 64'(out_channel), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_discard_count", 64'(exp_q.size()), 64'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    checkOutput("rst_hold_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_hold_out_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    pushExpected(0, pat(0, 4));
    pushExpected(1, pat(1, 4));
    pushExpected(2, pat(2, 4));
    @(negedge clk);
    checkOutput("restart_ready_0", 64'(in_ready), 64'h1);
    repeat (3) @(posedge clk);
    #1;
    idle(3);

    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
